// File: rtl/fifo_rd_downsizer.sv
// Read-side width converter: pops DATA_WIDTH*RATIO-bit words from an upstream FIFO
// and presents them as a lookahead FIFO of DATA_WIDTH-bit words, slice 0 first.
module fifo_rd_downsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int LOOKAHEAD  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        empty_i,
  output logic                        rd_i,
  input  logic [DATA_WIDTH*RATIO-1:0] dout_i,
  output logic                        empty,
  input  logic                        rd,
  output logic [DATA_WIDTH-1:0]       dout
);

  localparam int                 WIDE_W   = DATA_WIDTH * RATIO;
  localparam int                 IDX_W    = $clog2(RATIO);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(RATIO - 1);
  localparam bit                 LA_MODE  = (LOOKAHEAD != 0);

  logic [WIDE_W-1:0] r_buf_data;
  logic [IDX_W-1:0]  r_idx;
  logic              r_buf_valid;
  logic              r_pending;

  logic w_pop;
  logic w_last;
  logic w_free;
  logic w_load;

  assign w_pop  = rd && r_buf_valid;
  assign w_last = (r_idx == LAST_IDX);
  assign w_free = !r_buf_valid || (w_pop && w_last);

  // Gating with rst keeps an upstream word from being consumed by a cycle that
  // cannot capture it.
  assign rd_i   = !rst && !empty_i && w_free && (LA_MODE || !r_pending);
  assign w_load = LA_MODE ? rd_i : r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_data  <= '0;
      r_idx       <= '0;
      r_buf_valid <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_pending <= LA_MODE ? 1'b0 : rd_i;
      if (w_load) begin
        r_buf_data  <= dout_i;
        r_buf_valid <= 1'b1;
        r_idx       <= '0;
      end else if (w_pop) begin
        if (w_last) begin
          r_idx       <= '0;
          r_buf_valid <= 1'b0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_idx == IDX_W'(i)) dout = r_buf_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign empty = !r_buf_valid;

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Bench for fifo_rd_downsizer: one LOOKAHEAD=1 and one LOOKAHEAD=0 instance share rd/rst
// and are fed identical wide-word streams; a scoreboard checks every narrow pop.
module tb_fifo_rd_downsizer;
  localparam int DW    = 8;
  localparam int RT    = 4;
  localparam int WW    = DW * RT;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd  = 1'b0;

  logic          up_empty0, up_rd0, up_empty1, up_rd1;
  logic [WW-1:0] up_dout0;
  logic [WW-1:0] up_dout1 = '0;
  logic          dn_empty0, dn_empty1;
  logic [DW-1:0] dn_dout0, dn_dout1;

  logic [WW-1:0] up_mem0 [DEPTH];
  logic [WW-1:0] up_mem1 [DEPTH];
  logic [6:0]    up_wp0 = '0, up_wp1 = '0, up_rp0 = '0, up_rp1 = '0;
  int            rdi_cnt0 = 0, rdi_cnt1 = 0, la0_viol = 0, up_viol = 0;
  logic          la0_pending = 1'b0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_rd_downsizer #(.DATA_WIDTH(DW), .RATIO(RT), .LOOKAHEAD(1)) u_la1 (
    .clk(clk), .rst(rst), .empty_i(up_empty0), .rd_i(up_rd0), .dout_i(up_dout0),
    .empty(dn_empty0), .rd(rd), .dout(dn_dout0)
  );

  fifo_rd_downsizer #(.DATA_WIDTH(DW), .RATIO(RT), .LOOKAHEAD(0)) u_la0 (
    .clk(clk), .rst(rst), .empty_i(up_empty1), .rd_i(up_rd1), .dout_i(up_dout1),
    .empty(dn_empty1), .rd(rd), .dout(dn_dout1)
  );

  // Upstream FIFOs: lookahead one for u_la1, one-cycle read latency for u_la0.
  assign up_empty0 = (up_wp0 == up_rp0);
  assign up_dout0  = up_mem0[up_rp0];
  assign up_empty1 = (up_wp1 == up_rp1);

  always @(posedge clk) begin
    if (up_rd0) begin
      up_rp0   <= up_rp0 + 7'd1;
      rdi_cnt0 <= rdi_cnt0 + 1;
    end
    if (up_rd1) begin
      up_dout1 <= up_mem1[up_rp1];
      up_rp1   <= up_rp1 + 7'd1;
      rdi_cnt1 <= rdi_cnt1 + 1;
      if (la0_pending) la0_viol <= la0_viol + 1;
    end
    if ((up_rd0 && up_empty0) || (up_rd1 && up_empty1)) up_viol <= up_viol + 1;
    la0_pending <= up_rd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    up_mem0[up_wp0] = w;
    up_mem1[up_wp1] = w;
    up_wp0 = up_wp0 + 7'd1;
    up_wp1 = up_wp1 + 7'd1;
    for (int i = 0; i < RT; i++) begin
      exp_q0.push_back(w[i*DW +: DW]);
      exp_q1.push_back(w[i*DW +: DW]);
    end
  endtask

  task automatic mon_one(input int k, input string tag, input logic e, input logic [DW-1:0] d,
                         inout logic hold, inout logic [DW-1:0] pd);
    logic [DW-1:0] want;
    int n;
    n = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (hold) check($sformatf("hold_%s", tag), 64'({e, d}), 64'({1'b0, pd}));
    if (!e) begin
      check($sformatf("spurious_%s", tag), 64'(n != 0), 64'(1));
      if (rd && n != 0) begin
        if (k == 0) want = exp_q0.pop_front();
        else        want = exp_q1.pop_front();
        check($sformatf("data_%s", tag), 64'(d), 64'(want));
      end
    end
    hold = !e && !rd;
    pd   = d;
  endtask

  task automatic monitor();
    logic          hold0, hold1;
    logic [DW-1:0] pd0, pd1;
    hold0 = 1'b0; hold1 = 1'b0; pd0 = '0; pd1 = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold0 = 1'b0;
        hold1 = 1'b0;
      end else begin
        mon_one(0, "la1", dn_empty0, dn_dout0, hold0, pd0);
        mon_one(1, "la0", dn_empty1, dn_dout1, hold1, pd1);
      end
    end
  endtask

  task automatic run_span(input int ncyc, output int f0, output int l0, output int n0,
                          output int f1, output int l1, output int n1);
    f0 = -1; l0 = -1; n0 = 0; f1 = -1; l1 = -1; n1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c != 0) @(negedge clk);
      #3;
      if (!dn_empty0) begin if (f0 < 0) f0 = c; l0 = c; n0++; end
      if (!dn_empty1) begin if (f1 < 0) f1 = c; l1 = c; n1++; end
    end
  endtask

  task automatic drain(input string tag, input int max_cyc, input int rd_pct);
    int c;
    c = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < max_cyc) begin
      @(negedge clk);
      rd = ($urandom_range(0, 99) < rd_pct);
      #3;
      c++;
    end
    check($sformatf("drain_%s", tag), 64'(exp_q0.size() + exp_q1.size()), 64'(0));
    @(negedge clk);
    rd = 1'b0;
    #3;
    check($sformatf("empty_after_%s_la1", tag), 64'(dn_empty0), 64'(1));
    check($sformatf("empty_after_%s_la0", tag), 64'(dn_empty1), 64'(1));
  endtask

  initial begin
    int f0, l0, n0, f1, l1, n1, b0, b1, pushed;
    fork
      monitor();
    join_none

    // Reset state, with a word already waiting upstream.
    repeat (2) @(negedge clk);
    push_word(32'hF6A05A7A);
    rd = 1'b1;
    #2;
    check("rst_empty_la1", 64'(dn_empty0), 64'(1));
    check("rst_empty_la0", 64'(dn_empty1), 64'(1));
    check("rst_dout_la1", 64'(dn_dout0), 64'(0));
    check("rst_dout_la0", 64'(dn_dout1), 64'(0));
    check("rst_rdi_la1", 64'(up_rd0), 64'(0));
    check("rst_rdi_la0", 64'(up_rd1), 64'(0));

    // Single word with rd held high.
    b0 = rdi_cnt0; b1 = rdi_cnt1;
    @(negedge clk);
    rst = 1'b0;
    run_span(10, f0, l0, n0, f1, l1, n1);
    check("single_first_la1", 64'(f0), 64'(1));
    check("single_last_la1", 64'(l0), 64'(4));
    check("single_count_la1", 64'(n0), 64'(4));
    check("single_first_la0", 64'(f1), 64'(2));
    check("single_last_la0", 64'(l1), 64'(5));
    check("single_count_la0", 64'(n1), 64'(4));
    check("single_empty_la1", 64'(dn_empty0), 64'(1));
    check("single_empty_la0", 64'(dn_empty1), 64'(1));
    check("single_rdi_la1", 64'(rdi_cnt0 - b0), 64'(1));
    check("single_rdi_la0", 64'(rdi_cnt1 - b1), 64'(1));

    // Streaming two words back to back.
    @(negedge clk);
    push_word(32'h7AA0E281);
    push_word(32'hC409F65A);
    run_span(14, f0, l0, n0, f1, l1, n1);
    check("stream_first_la1", 64'(f0), 64'(1));
    check("stream_last_la1", 64'(l0), 64'(8));
    check("stream_count_la1", 64'(n0), 64'(8));
    check("stream_first_la0", 64'(f1), 64'(2));
    check("stream_last_la0", 64'(l1), 64'(10));
    check("stream_count_la0", 64'(n1), 64'(8));
    check("stream_queue", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

    // Same two words with rd randomised at 50%.
    @(negedge clk);
    push_word(32'h7AA0E281);
    push_word(32'hC409F65A);
    drain("stall", 300, 50);

    // Reset after two pops on the lookahead instance.
    @(negedge clk);
    rd = 1'b1;
    push_word(32'hF6A05A7A);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst = 1'b0;
    rd  = 1'b0;
    #2;
    check("midrst_empty_la1", 64'(dn_empty0), 64'(1));
    check("midrst_empty_la0", 64'(dn_empty1), 64'(1));
    check("midrst_dout_la1", 64'(dn_dout0), 64'(0));
    check("midrst_dout_la0", 64'(dn_dout1), 64'(0));
    @(negedge clk);
    push_word(32'h11223344);
    drain("after_rst", 50, 100);

    // Upstream empty for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rd = $urandom_range(0, 1) == 1;
      #3;
      check("idle_rdi_la1", 64'(up_rd0), 64'(0));
      check("idle_rdi_la0", 64'(up_rd1), 64'(0));
      check("idle_empty_la1", 64'(dn_empty0), 64'(1));
      check("idle_empty_la0", 64'(dn_empty1), 64'(1));
    end

    // Random words arriving at random times, random rd.
    pushed = 0;
    for (int c = 0; c < 3000 && (pushed < 40 || exp_q0.size() != 0 || exp_q1.size() != 0); c++) begin
      @(negedge clk);
      rd = ($urandom_range(0, 99) < 70);
      if (pushed < 40 && $urandom_range(0, 2) == 0) begin
        push_word($urandom());
        pushed++;
      end
      #3;
    end
    drain("random", 200, 100);

    check("la0_rdi_while_pending", 64'(la0_viol), 64'(0));
    check("upstream_pop_while_empty", 64'(up_viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_downsizer.md
# fifo_rd_downsizer

Read-side width converter placed after a FIFO's read port. It pops wide words (DATA_WIDTH×RATIO bits) from an upstream FIFO through the empty/rd/dout handshake. It re-presents them as a stream of narrow DATA_WIDTH-bit words on a lookahead FIFO read interface (empty/rd/dout), least-significant slice first. Downstream logic sees it as an ordinary lookahead FIFO of narrow words.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of each output word.
- RATIO, default 4: output words per input word; legal values are ≥2.
- LOOKAHEAD, default 1: upstream read mode.
  - 1: upstream dout_i is valid whenever !empty_i; rd_i pops it.
  - 0: data appears on dout_i the cycle after rd_i.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- empty_i  in  1  upstream FIFO empty.
- rd_i  out  1  upstream pop request (combinational).
- dout_i  in  DATA_WIDTH*RATIO  upstream read data.
- empty  out  1  no narrow word available (registered).
- rd  in  1  downstream pop; ignored while empty=1.
- dout  out  DATA_WIDTH  current narrow word; valid whenever empty=0.

## Operation
- State:
  - buf_data[DATA_WIDTH*RATIO-1:0]: holding register for the current wide word.
  - idx, $clog2(RATIO) bits: index of the next slice to output.
  - buf_valid: holding register contains a word.
  - pending: used only when LOOKAHEAD=0; an upstream read is in flight.
- Output mapping:
  - dout = buf_data[idx*DATA_WIDTH +: DATA_WIDTH].
  - empty = !buf_valid.
- Pop:
  - pop = rd && buf_valid.
  - last = (idx == RATIO-1).
  - On pop && !last: idx ← idx+1.
  - On pop && last: idx ← 0 and buf_valid ← 0, unless a reload occurs in the same cycle.
- Free condition: free = !buf_valid || (pop && last).
- LOOKAHEAD=1:
  - rd_i = !empty_i && free.
  - On rd_i: buf_data ← dout_i, buf_valid ← 1, idx ← 0, all at the same edge.
  - Back-to-back wide words therefore stream without a bubble.
- LOOKAHEAD=0:
  - rd_i = !empty_i && free && !pending.
  - pending ← rd_i.
  - When pending=1: buf_data ← dout_i, buf_valid ← 1, idx ← 0.
  - One bubble cycle (empty=1) occurs between consecutive wide words.
  - A pop is impossible while pending=1, because buf_valid=0 then.
- Slice ordering: slice 0 is bits [DATA_WIDTH-1:0], output first.
- rd while empty=1: no effect, no state change, no error.
- The block never drops or duplicates a wide word. Every popped wide word yields exactly RATIO narrow words.

## Timing
- Reset values: buf_valid=0, idx=0, pending=0, buf_data=0. Consequently empty=1, dout=0, and rd_i=0 during the rst cycle.
- rst takes priority over every other event.
  - A mid-word reset discards the remaining slices.
  - With LOOKAHEAD=0, a reset during pending=1 discards the in-flight upstream word. It is consumed upstream and lost, which is the required behaviour.
- Latency, LOOKAHEAD=1: a word present upstream at edge N is accepted at edge N+1 (with rd_i high in the preceding cycle), and empty falls after that edge.
- Latency, LOOKAHEAD=0: add one cycle to the LOOKAHEAD=1 figure.
- Throughput: one narrow word per cycle in both modes.
  - LOOKAHEAD=1 sustains this with no gaps.
  - LOOKAHEAD=0 loses one cycle per RATIO output words.
- rd_i depends combinationally on empty_i and rd. There is no combinational path from rd to empty or dout.
- Simultaneous last-slice pop and reload: the new word is visible on the next cycle with idx=0, and empty stays 0 (LOOKAHEAD=1).

## Test plan
All tests use defaults DATA_WIDTH=8, RATIO=4, unless stated otherwise.
- Single word: upstream holds 32'hF6A05A7A and rd is held high. Required:
  - dout = 7A, 5A, A0, F6 on four consecutive cycles.
  - empty=1 afterwards.
  - rd_i pulses exactly once.
- Streaming: upstream holds 32'h7AA0E281 then 32'hC409F65A; rd held high (LOOKAHEAD=1). Required:
  - Eight consecutive outputs 81, E2, A0, 7A, 5A, F6, 09, C4.
  - empty never rises between words.
- Random rd stall: same two words, rd randomised at 50%. Required:
  - Output sequence identical to the streaming case.
  - dout holds stable while rd=0.
  - rd while empty=1 changes nothing.
- LOOKAHEAD=0 with 1-cycle-latency upstream, same two words, rd high. Required:
  - The eight values above, with exactly one empty=1 cycle between F6-group boundaries (after 7A).
  - rd_i never asserts while pending=1.
- Reset mid-word: assert rst after two pops of 32'hF6A05A7A. Required:
  - empty=1 and dout=0 the next cycle.
  - The following upstream word 32'h11223344 yields 44, 33, 22, 11.
- Upstream empty: hold empty_i=1 for 20 cycles. Required: rd_i=0 and empty=1 throughout, with no spurious outputs.
